seq_div8: RTL and testbench

SEQ_DIV8 -- requirements
Module: seq_div8

---
 rtl/seq_div8.sv | 114 +++++++++++
 tb/tb_seq_div8.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_div8.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero bypasses the iteration and reports q = all ones, r = dividend.
module seq_div8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Partial remainder is always < divisor, so trial[WIDTH] is exactly the borrow.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (b == '0) begin
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        dvd_d   = a;
                        dsr_d   = b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    q_d     = dvd_d;
                    r_d     = rem_d;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: directed vector table, hand-written
// multi-cycle sequences, and a random back-to-back sweep against a / and % model.
module tb_seq_div8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    int tests = 0;
    int fails = 0;

    seq_div8 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edbz;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Starts an operation in the current cycle and returns in its done cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] eq,
                          input logic [7:0] er, input logic edbz, input string name);
        logic [7:0] pq;
        logic [7:0] pr;
        int         lat;
        pq  = q;
        pr  = r;
        lat = (tb_ == 8'd0) ? 1 : 9;
        a     = ta;
        b     = tb_;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        for (int c = 1; c < lat; c++) begin
            chk({name, " busy"}, int'(busy), 1);
            chk({name, " done_early"}, int'(done), 0);
            chk({name, " q_held"}, int'(q), int'(pq));
            chk({name, " r_held"}, int'(r), int'(pr));
            tick();
        end
        chk({name, " done"}, int'(done), 1);
        chk({name, " busy_at_done"}, int'(busy), 0);
        chk({name, " q"}, int'(q), int'(eq));
        chk({name, " r"}, int'(r), int'(er));
        chk({name, " dbz"}, int'(dbz), int'(edbz));
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] mq;
        logic [7:0] mr;
        int         ndone;

        vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,   1'b0});
        vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0});
        vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0});
        vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
        vecs.push_back('{8'd100, 8'd0,   8'd255, 8'd100, 1'b1});
        vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0});
        vecs.push_back('{8'd0,   8'd0,   8'd255, 8'd0,   1'b1});
        vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0});
        vecs.push_back('{8'd128, 8'd2,   8'd64,  8'd0,   1'b0});

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        tick();
        tick();
        chk("reset q", int'(q), 0);
        chk("reset r", int'(r), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset dbz", int'(dbz), 0);
        rst = 1'b0;

        // First start right after reset release, then the vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edbz,
                   $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d done_one_cycle", i), int'(done), 0);
            chk($sformatf("vec%0d idle_busy", i), int'(busy), 0);
            chk($sformatf("vec%0d q_hold_idle", i), int'(q), int'(vecs[i].eq));
            chk($sformatf("vec%0d r_hold_idle", i), int'(r), int'(vecs[i].er));
        end

        // Back-to-back: second start issued in the done cycle of the first.
        run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "b2b_first");
        run_op(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, "b2b_second");
        tick();

        // Start during RUN is ignored; exactly one done pulse.
        ndone = 0;
        a     = 8'd50;
        b     = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 4) begin
                a     = 8'd9;
                b     = 8'd2;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) ndone++;
            if (cyc + 1 == 9) begin
                chk("ign done", int'(done), 1);
                chk("ign q", int'(q), 16);
                chk("ign r", int'(r), 2);
            end
        end
        chk("ign done_count", ndone, 1);

        // Reset mid-RUN aborts; restart in the first cycle after reset.
        a     = 8'd200;
        b     = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort q", int'(q), 0);
        chk("abort r", int'(r), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort dbz", int'(dbz), 0);
        run_op(8'd20, 8'd6, 8'd3, 8'd2, 1'b0, "after_abort");

        // Random back-to-back sweep against a / and % model.
        for (int n = 0; n < 3000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if (rb == 8'd0) begin
                mq = 8'hff;
                mr = ra;
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            run_op(ra, rb, mq, mr, (rb == 8'd0), $sformatf("rnd a=%0d b=%0d", ra, rb));
        end
        tick();
        chk("final done_low", int'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
